// File: rtl/mr_noc_pkg.sv
// Shared definitions for the MapReduce NoC text dispatcher: default sizes and FSM encoding.
package mr_noc_pkg;

  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned NODE_NUM  = 4;
  localparam int unsigned KEY_WORDS = 4;
  localparam int unsigned CHUNK     = 8;
  localparam int unsigned WR_GAP    = 6;
  localparam int unsigned NODE_W    = $clog2(NODE_NUM);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_KEY_LOAD  = 3'd1;
  localparam logic [2:0] S_KEY_BCAST = 3'd2;
  localparam logic [2:0] S_DISPATCH  = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  typedef enum logic [2:0] {
    DispIdle     = S_IDLE,
    DispKeyLoad  = S_KEY_LOAD,
    DispKeyBcast = S_KEY_BCAST,
    DispDispatch = S_DISPATCH,
    DispDrain    = S_DRAIN,
    DispDone     = S_DONE
  } disp_state_t;

endpackage

// File: rtl/wr_gap_timer.sv
// Per-node write pacing timer: loads a fixed gap value and counts down to zero.
module wr_gap_timer #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned LOAD_VAL = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  output logic zero
);
  import mr_noc_pkg::*;

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (load) begin
      // A load wins over the decrement in the same cycle.
      count_q <= WIDTH'(LOAD_VAL);
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/text_dispatcher.sv
// Loads a keyword, broadcasts it to all nodes, then deals text words to nodes in chunks.
module text_dispatcher #(
  parameter int unsigned DATA_SIZE = mr_noc_pkg::DATA_SIZE,
  parameter int unsigned NODE_NUM  = mr_noc_pkg::NODE_NUM,
  parameter int unsigned KEY_WORDS = mr_noc_pkg::KEY_WORDS,
  parameter int unsigned CHUNK     = mr_noc_pkg::CHUNK,
  parameter int unsigned WR_GAP    = mr_noc_pkg::WR_GAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] key_in,
  input  logic                 key_wr,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] keyword,
  output logic                 key_en,
  output logic [DATA_SIZE-1:0] textfile,
  output logic [NODE_NUM-1:0]  data_wr,
  output logic                 busy,
  output logic                 done
);
  import mr_noc_pkg::*;

  localparam int unsigned TW = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
  localparam int unsigned KW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int unsigned CW = $clog2(CHUNK + 1);
  localparam int unsigned GW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

  disp_state_t          state_q, state_d;
  logic [KW-1:0]        key_cnt_q, key_cnt_d;
  logic [TW-1:0]        target_q, target_d;
  logic [CW-1:0]        chunk_cnt_q, chunk_cnt_d;
  logic [DATA_SIZE-1:0] key_buf_q [KEY_WORDS];
  logic [DATA_SIZE-1:0] textfile_q;
  logic [NODE_NUM-1:0]  data_wr_q;
  logic [NODE_NUM-1:0]  gap_zero;
  logic [NODE_NUM-1:0]  gap_load;
  logic                 gap_clear;
  logic                 hs;

  assign in_ready = (state_q == DispDispatch) && gap_zero[target_q];
  assign hs       = in_valid && in_ready;
  assign busy     = (state_q != DispIdle);
  assign done     = (state_q == DispDone);
  assign key_en   = (state_q == DispKeyBcast);
  assign textfile = textfile_q;
  assign data_wr  = data_wr_q;

  always_comb begin
    keyword = '0;
    if (state_q == DispKeyBcast) begin
      keyword = key_buf_q[key_cnt_q];
    end
  end

  for (genvar k = 0; k < NODE_NUM; k++) begin : g_gap
    assign gap_load[k] = hs && (target_q == TW'(k));

    wr_gap_timer #(
      .WIDTH   (GW),
      .LOAD_VAL(WR_GAP)
    ) u_gap (
      .clk  (clk),
      .rst  (rst),
      .clear(gap_clear),
      .load (gap_load[k]),
      .zero (gap_zero[k])
    );
  end

  // key_cnt doubles as the broadcast index once the keyword is captured.
  always_comb begin
    state_d     = state_q;
    key_cnt_d   = key_cnt_q;
    target_d    = target_q;
    chunk_cnt_d = chunk_cnt_q;
    gap_clear   = 1'b0;
    unique case (state_q)
      DispIdle: begin
        if (start) begin
          state_d     = DispKeyLoad;
          key_cnt_d   = '0;
          target_d    = '0;
          chunk_cnt_d = '0;
          gap_clear   = 1'b1;
        end
      end
      DispKeyLoad: begin
        if (key_wr) begin
          if (key_cnt_q == KW'(KEY_WORDS - 1)) begin
            key_cnt_d = '0;
            state_d   = DispKeyBcast;
          end else begin
            key_cnt_d = key_cnt_q + KW'(1);
          end
        end
      end
      DispKeyBcast: begin
        if (key_cnt_q == KW'(KEY_WORDS - 1)) begin
          key_cnt_d = '0;
          state_d   = DispDispatch;
        end else begin
          key_cnt_d = key_cnt_q + KW'(1);
        end
      end
      DispDispatch: begin
        if (hs) begin
          if (chunk_cnt_q == CW'(CHUNK - 1)) begin
            chunk_cnt_d = '0;
            target_d    = (target_q == TW'(NODE_NUM - 1)) ? '0 : target_q + TW'(1);
          end else begin
            chunk_cnt_d = chunk_cnt_q + CW'(1);
          end
          if (in_last) begin
            state_d = DispDrain;
          end
        end
      end
      DispDrain: begin
        if (&gap_zero) begin
          state_d = DispDone;
        end
      end
      DispDone: begin
        state_d = DispIdle;
      end
      default: begin
        state_d = DispIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DispIdle;
      key_cnt_q   <= '0;
      target_q    <= '0;
      chunk_cnt_q <= '0;
      textfile_q  <= '0;
      data_wr_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_cnt_q   <= key_cnt_d;
      target_q    <= target_d;
      chunk_cnt_q <= chunk_cnt_d;
      data_wr_q   <= hs ? (NODE_NUM'(1) << target_q) : '0;
      if (hs) begin
        textfile_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_buf_q[i] <= '0;
      end
    end else if ((state_q == DispKeyLoad) && key_wr) begin
      key_buf_q[key_cnt_q] <= key_in;
    end
  end

endmodule

// File: tb/tb_text_dispatcher.sv
// Scoreboard bench for text_dispatcher: key broadcast, paced round-robin dispatch, drain, reset.
module tb_text_dispatcher;

  localparam int NN  = 4;
  localparam int CH  = 2;
  localparam int GAP = 6;
  localparam int KWN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        key_wr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] key_in = '0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] keyword;
  logic        key_en;
  logic [31:0] textfile;
  logic [NN-1:0] data_wr;
  logic        busy;
  logic        done;

  text_dispatcher #(
    .DATA_SIZE(32),
    .NODE_NUM (NN),
    .KEY_WORDS(KWN),
    .CHUNK    (CH),
    .WR_GAP   (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_in  (key_in),
    .key_wr  (key_wr),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .keyword (keyword),
    .key_en  (key_en),
    .textfile(textfile),
    .data_wr (data_wr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_wr[NN];
  logic [35:0] sb[$];
  logic [31:0] kw[KWN];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Output monitor: every data_wr pulse must match the oldest expected write.
  always @(negedge clk) begin : mon
    logic [35:0] e;
    if (rst) begin
      if (done) done_cnt++;
      if (data_wr != '0) begin
        if (sb.size() == 0) begin
          check_eq("wr_unexpected", {60'd0, data_wr}, 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("wr_word", {28'd0, data_wr, textfile}, {28'd0, e});
        end
        for (int k = 0; k < NN; k++) begin
          if (data_wr[k]) begin
            check_eq("wr_gap_ok", (cyc - last_wr[k] >= GAP + 1) ? 64'd1 : 64'd0, 64'd1);
            last_wr[k] = cyc;
          end
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check_eq({tag, "_keyword"}, {32'd0, keyword}, 64'd0);
    check_eq({tag, "_key_en"}, {63'd0, key_en}, 64'd0);
    check_eq({tag, "_textfile"}, {32'd0, textfile}, 64'd0);
    check_eq({tag, "_data_wr"}, {60'd0, data_wr}, 64'd0);
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  task automatic load_key();
    for (int k = 0; k < NN; k++) last_wr[k] = -100;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < KWN; i++) begin
      key_wr = 1'b1;
      key_in = kw[i];
      tick();
    end
    key_wr = 1'b0;
    for (int i = 0; i < KWN; i++) begin
      check_eq("bcast_key_en", {63'd0, key_en}, 64'd1);
      check_eq("bcast_keyword", {32'd0, keyword}, {32'd0, kw[i]});
      check_eq("bcast_no_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    check_eq("post_bcast_key_en", {63'd0, key_en}, 64'd0);
    check_eq("post_bcast_keyword", {32'd0, keyword}, 64'd0);
    check_eq("post_bcast_ready", {63'd0, in_ready}, 64'd1);
  endtask

  // Holds in_valid high; pushes the model's expected write at each handshake.
  task automatic send_words(input int n, input int last_at, input bit inject, output int hs_cyc);
    bit got;
    logic [NN-1:0] oh;
    hs_cyc = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 32'h7965_6854 : 32'h1000_0000 + 32'(i);
      in_last  = (i == last_at);
      if (inject && i == 3) begin
        start  = 1'b1;
        key_wr = 1'b1;
        key_in = 32'hffff_ffff;
      end
      got = 1'b0;
      for (int b = 0; b < 40 && !got; b++) begin
        if (in_ready) begin
          oh = NN'(1) << ((i / CH) % NN);
          sb.push_back({oh, in_data});
          hs_cyc = cyc;
          got = 1'b1;
        end
        tick();
        start  = 1'b0;
        key_wr = 1'b0;
      end
      check_eq("handshake", {63'd0, got}, 64'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int hs_cyc);
    bit got;
    int dc;
    got = 1'b0;
    dc = done_cnt;
    for (int b = 0; b < 60 && !got; b++) begin
      if (done) got = 1'b1;
      else tick();
    end
    check_eq("done_seen", {63'd0, got}, 64'd1);
    if (got) begin
      check_eq("done_delay_ok", (cyc - hs_cyc >= GAP + 1) ? 64'd1 : 64'd0, 64'd1);
      check_eq("busy_at_done", {63'd0, busy}, 64'd1);
      tick();
      check_eq("done_single", {63'd0, done}, 64'd0);
      check_eq("busy_fall", {63'd0, busy}, 64'd0);
      check_eq("done_count", 64'(done_cnt - dc), 64'd1);
    end
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h;
    int dc;
    kw[0] = 32'h6d65_6874;
    kw[1] = 32'h766c_6573;
    kw[2] = 32'h0000_7365;
    kw[3] = 32'h0000_0000;

    repeat (3) @(negedge clk);
    check_zero_outputs("in_reset");
    rst = 1'b1;
    tick();
    check_zero_outputs("idle");

    // Job 1: ten words round-robin with ignored start/key_wr mid-dispatch.
    load_key();
    send_words(10, 9, 1'b1, h);
    wait_done(h);
    check_eq("key_buf0_kept", {32'd0, dut.key_buf_q[0]}, {32'd0, kw[0]});
    check_eq("key_buf3_kept", {32'd0, dut.key_buf_q[3]}, {32'd0, kw[3]});
    in_valid = 1'b1;
    tick();
    check_eq("idle_no_ready", {63'd0, in_ready}, 64'd0);
    check_eq("idle_not_busy", {63'd0, busy}, 64'd0);
    in_valid = 1'b0;
    repeat (3) tick();

    // Job 2: aborted by reset during dispatch.
    load_key();
    send_words(3, -1, 1'b0, h);
    tick();
    dc = done_cnt;
    rst = 1'b0;
    #1;
    check_zero_outputs("abort");
    repeat (3) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    check_eq("abort_no_done", 64'(done_cnt), 64'(dc));
    check_zero_outputs("after_abort");

    // Job 3: fresh job, last flag on word 5.
    load_key();
    send_words(5, 4, 1'b0, h);
    wait_done(h);
    in_valid = 1'b1;
    tick();
    check_eq("final_no_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
